// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle sequencer for the simple RISC-V datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// arbitrating the shared ALU and the single memory port.
// Optional build macro: MULTICYCLE_CTRL_PERF_EN adds a retired-instruction
// counter on output port instret.
module multicycle_control #(
  parameter int TRAP_HALT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_ALU = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_TRAP   = 4'd10;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // Next-state selection; memory states hold until the access completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_BR:             state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: state_d = S_WB_ALU;
      S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR:   state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_WB_ALU: state_d = S_FETCH;
      S_WB_MEM: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = (TRAP_HALT != 0) ? S_TRAP : S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Control-point decode of the current state; everything is held low in reset.
  always_comb begin
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    branch     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    state      = 4'd0;
    if (!rst) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          // IR and PC+4 are captured only when the fetch actually lands.
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          // Precompute the branch target into ALUOut.
          alu_src_b = 2'b10;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          branch    = 1'b1;
          pc_src    = 1'b1;
          pc_write  = zero;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instret_q;
  logic        retire;

  // An instruction retires when its last state hands control back to FETCH.
  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_WB_ALU) || (state_q == S_WB_MEM) ||
                   (state_q == S_MEM_WR) || (state_q == S_BRANCH));

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst)         instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = rst ? 32'd0 : instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vectors for multicycle_control.
// dut0 runs with TRAP_HALT=1, dut1 with TRAP_HALT=0; both share the inputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       mem_req0, mem_read0, mem_write0, i_or_d0, ir_write0, pc_write0;
  logic       pc_src0, alu_src_a0, branch0, reg_write0, mem_to_reg0, illegal0;
  logic [1:0] alu_src_b0, alu_op0;
  logic [3:0] state0;
  logic       mem_req1, mem_read1, mem_write1, i_or_d1, ir_write1, pc_write1;
  logic       pc_src1, alu_src_a1, branch1, reg_write1, mem_to_reg1, illegal1;
  logic [1:0] alu_src_b1, alu_op1;
  logic [3:0] state1;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instret0, instret1;
`endif

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control #(.TRAP_HALT(1)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req0), .mem_read(mem_read0), .mem_write(mem_write0),
    .i_or_d(i_or_d0), .ir_write(ir_write0), .pc_write(pc_write0),
    .pc_src(pc_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
    .alu_op(alu_op0), .branch(branch0), .reg_write(reg_write0),
    .mem_to_reg(mem_to_reg0), .illegal(illegal0), .state(state0)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .instret(instret0)
`endif
  );

  multicycle_control #(.TRAP_HALT(0)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req1), .mem_read(mem_read1), .mem_write(mem_write1),
    .i_or_d(i_or_d1), .ir_write(ir_write1), .pc_write(pc_write1),
    .pc_src(pc_src1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
    .alu_op(alu_op1), .branch(branch1), .reg_write(reg_write1),
    .mem_to_reg(mem_to_reg1), .illegal(illegal1), .state(state1)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .instret(instret1)
`endif
  );

  // Packed view: req rd wr iod | irw pcw pcsrc | asa | asb | aop | br rw m2r ill | state
  logic [19:0] obs0, obs1;
  assign obs0 = {mem_req0, mem_read0, mem_write0, i_or_d0, ir_write0, pc_write0,
                 pc_src0, alu_src_a0, alu_src_b0, alu_op0, branch0, reg_write0,
                 mem_to_reg0, illegal0, state0};
  assign obs1 = {mem_req1, mem_read1, mem_write1, i_or_d1, ir_write1, pc_write1,
                 pc_src1, alu_src_a1, alu_src_b1, alu_op1, branch1, reg_write1,
                 mem_to_reg1, illegal1, state1};

  localparam logic [19:0] V_ZERO    = 20'b0000_000_0_00_00_0000_0000;
  localparam logic [19:0] V_FETCH_W = 20'b1100_000_0_01_00_0000_0000;
  localparam logic [19:0] V_FETCH_R = 20'b1100_110_0_01_00_0000_0000;
  localparam logic [19:0] V_DECODE  = 20'b0000_000_0_10_00_0000_0001;
  localparam logic [19:0] V_EXEC_R  = 20'b0000_000_1_00_10_0000_0010;
  localparam logic [19:0] V_EXEC_I  = 20'b0000_000_1_10_11_0000_0011;
  localparam logic [19:0] V_ADDR    = 20'b0000_000_1_10_00_0000_0100;
  localparam logic [19:0] V_MEM_RD  = 20'b1101_000_0_00_00_0000_0101;
  localparam logic [19:0] V_MEM_WR  = 20'b1011_000_0_00_00_0000_0110;
  localparam logic [19:0] V_WB_ALU  = 20'b0000_000_0_00_00_0100_0111;
  localparam logic [19:0] V_WB_MEM  = 20'b0000_000_0_00_00_0110_1000;
  localparam logic [19:0] V_BR_T    = 20'b0000_011_1_00_01_1000_1001;
  localparam logic [19:0] V_BR_N    = 20'b0000_001_1_00_01_1000_1001;
  localparam logic [19:0] V_TRAP    = 20'b0000_000_0_00_00_0001_1010;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_IL = 7'b1111111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One clock cycle: drive inputs, check dut0 mid-cycle, then advance.
  task automatic cyc(input string tag, input logic r, input logic [6:0] op,
                     input logic mr, input logic z, input logic [19:0] exp);
    rst = r; opcode = op; mem_ready = mr; zero = z;
    #1;
    check(tag, {12'd0, obs0}, {12'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk); #1;

    // Reset holds everything low even with mem_ready high.
    cyc("reset_outputs", 1'b1, OP_R, 1'b1, 1'b0, V_ZERO);

    // R-type, zero-wait: 0,1,2,7 then FETCH.
    cyc("r_fetch",  1'b0, OP_R, 1'b1, 1'b0, V_FETCH_R);
    cyc("r_decode", 1'b0, OP_R, 1'b1, 1'b0, V_DECODE);
    cyc("r_exec",   1'b0, OP_R, 1'b1, 1'b0, V_EXEC_R);
    cyc("r_wb",     1'b0, OP_R, 1'b1, 1'b0, V_WB_ALU);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check("instret_after_r", instret0, 32'd1);
`endif

    // I-type with one fetch wait cycle.
    cyc("i_fetch_wait", 1'b0, OP_I, 1'b0, 1'b0, V_FETCH_W);
    cyc("i_fetch",      1'b0, OP_I, 1'b1, 1'b0, V_FETCH_R);
    cyc("i_decode",     1'b0, OP_I, 1'b0, 1'b0, V_DECODE);
    cyc("i_exec",       1'b0, OP_I, 1'b0, 1'b0, V_EXEC_I);
    cyc("i_wb",         1'b0, OP_I, 1'b0, 1'b0, V_WB_ALU);

    // Load with two memory wait cycles: 7 cycles total.
    cyc("ld_fetch",   1'b0, OP_LD, 1'b1, 1'b0, V_FETCH_R);
    cyc("ld_decode",  1'b0, OP_LD, 1'b1, 1'b0, V_DECODE);
    cyc("ld_addr",    1'b0, OP_LD, 1'b1, 1'b0, V_ADDR);
    cyc("ld_wait1",   1'b0, OP_LD, 1'b0, 1'b0, V_MEM_RD);
    cyc("ld_wait2",   1'b0, OP_LD, 1'b0, 1'b0, V_MEM_RD);
    cyc("ld_done",    1'b0, OP_LD, 1'b1, 1'b0, V_MEM_RD);
    cyc("ld_wb",      1'b0, OP_LD, 1'b1, 1'b0, V_WB_MEM);

    // Store, zero-wait: 4 cycles, no writeback.
    cyc("st_fetch",  1'b0, OP_ST, 1'b1, 1'b0, V_FETCH_R);
    cyc("st_decode", 1'b0, OP_ST, 1'b1, 1'b0, V_DECODE);
    cyc("st_addr",   1'b0, OP_ST, 1'b1, 1'b0, V_ADDR);
    cyc("st_mem",    1'b0, OP_ST, 1'b1, 1'b0, V_MEM_WR);

    // Branch taken, then not taken.
    cyc("bt_fetch",  1'b0, OP_BR, 1'b1, 1'b1, V_FETCH_R);
    cyc("bt_decode", 1'b0, OP_BR, 1'b1, 1'b1, V_DECODE);
    cyc("bt_branch", 1'b0, OP_BR, 1'b1, 1'b1, V_BR_T);
    cyc("bn_fetch",  1'b0, OP_BR, 1'b1, 1'b0, V_FETCH_R);
    cyc("bn_decode", 1'b0, OP_BR, 1'b1, 1'b0, V_DECODE);
    cyc("bn_branch", 1'b0, OP_BR, 1'b1, 1'b0, V_BR_N);
    cyc("post_branch_fetch", 1'b0, OP_BR, 1'b0, 1'b0, V_FETCH_W);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check("instret_after_mix", instret0, 32'd6);
`endif

    // Reset during a load wait abandons it.
    cyc("rw_fetch",  1'b0, OP_LD, 1'b1, 1'b0, V_FETCH_R);
    cyc("rw_decode", 1'b0, OP_LD, 1'b1, 1'b0, V_DECODE);
    cyc("rw_addr",   1'b0, OP_LD, 1'b1, 1'b0, V_ADDR);
    cyc("rw_wait",   1'b0, OP_LD, 1'b0, 1'b0, V_MEM_RD);
    cyc("rw_rst1",   1'b1, OP_LD, 1'b0, 1'b0, V_ZERO);
    cyc("rw_rst2",   1'b1, OP_LD, 1'b1, 1'b0, V_ZERO);
    cyc("rw_after",  1'b0, OP_LD, 1'b0, 1'b0, V_FETCH_W);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check("instret_after_rst", instret0, 32'd0);
`endif

    // Illegal opcode: dut0 halts in TRAP, dut1 returns to FETCH after one cycle.
    cyc("il_fetch",  1'b0, OP_IL, 1'b1, 1'b0, V_FETCH_R);
    cyc("il_decode", 1'b0, OP_IL, 1'b0, 1'b0, V_DECODE);
    for (int i = 0; i < 10; i++) begin
      rst = 1'b0; opcode = OP_IL; mem_ready = 1'b0; zero = 1'b0;
      #1;
      check($sformatf("trap_hold_%0d", i), {12'd0, obs0}, {12'd0, V_TRAP});
      if (i == 0) check("trap_once_in",  {12'd0, obs1}, {12'd0, V_TRAP});
      if (i == 1) check("trap_once_out", {12'd0, obs1}, {12'd0, V_FETCH_W});
      @(posedge clk); #1;
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    check("instret_trap_exit", instret1, 32'd0);
`endif
    cyc("trap_rst",   1'b1, OP_IL, 1'b0, 1'b0, V_ZERO);
    cyc("trap_after", 1'b0, OP_IL, 1'b0, 1'b0, V_FETCH_W);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
